tt_um_mult_ctrl: RTL and testbench
==================================

TT_UM_MULT_CTRL -- requirements
Module: tt_um_mult_ctrl
Sequencer for the ternary mat-vec multiplier: loads weights and vector, drives row/VecIn/W, deserialises VecOut.

Interface
REQ-001 SHALL have parameter InLen, default 14, input vector length; only the default is supported.
REQ-002 SHALL have parameter OutLen, default 7, output vector length; only the default is supported.
REQ-003 SHALL have parameter BitWidth, default 8, element width; only the default is supported.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 8), forming the load byte stream.
REQ-007 SHALL have port start, input, 1, single-cycle compute request.
REQ-008 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have ports row (output, 3), VecIn (output, 16) and W (output, 28), driving the multiplier.
REQ-010 SHALL have port VecOut, input, 8, serial result from the multiplier.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1) and res_data (output, 8), forming the result stream.

Function
REQ-012 SHALL accept a byte when in_valid && in_ready; in_ready SHALL be high only in IDLE with load count < 42.
REQ-013 SHALL store load bytes 0-27 as seven 28-bit step words: 4 bytes each, little-endian, byte 3 bits[7:4] ignored; weight code bit1=negate, bit0=pass, bit1 has precedence.
REQ-014 SHALL store load bytes 28-41 as vector elements x0..x13.
REQ-015 SHALL ignore start unless in IDLE with load count == 42; start is sampled before in_valid in the same cycle.
REQ-016 SHALL implement the states IDLE -> RUN -> FLUSH -> DRAIN -> OUT -> IDLE.
REQ-017 RUN SHALL last 7 cycles, s = 0..6, driving row = s, W = step word s and VecIn = {x[2s+1], x[2s]}.
REQ-018 FLUSH SHALL last 1 cycle, driving row = 0, W = 0 and VecIn = 0.
REQ-019 DRAIN SHALL last 7 cycles, driving row = 1..6 then 0, with W = 0 and VecIn = 0.
REQ-020 DRAIN SHALL capture VecOut in each of its 7 cycles as y0..y6; y0 SHALL be sampled 8 cycles after the first RUN cycle.
REQ-021 OUT SHALL present y0..y6 in order on res_data; res_valid SHALL stay high and res_data stable until res_ready.
REQ-022 After the y6 handshake, the block SHALL return to IDLE, clear the load count to 0 and require a full 42-byte reload.
REQ-023 In IDLE, row, W and VecIn SHALL be 0.
REQ-024 Results are two's-complement 8-bit, wrap-around; no saturation.

Reset
REQ-025 rst SHALL, in any state including mid-RUN, DRAIN or OUT, force IDLE on the next edge.
REQ-026 rst SHALL set load count = 0, in_ready = 1, busy = 0, res_valid = 0, res_data = 0, row = 0, W = 0 and VecIn = 0.
REQ-027 Buffer contents need not be cleared by rst; they are unobservable until reloaded.

Configuration
REQ-028 With macro TT_MULT_CTRL_RELU_EN defined, each captured y SHALL be replaced by 0 when its bit 7 is set.
REQ-029 Without TT_MULT_CTRL_RELU_EN, captured values SHALL pass through unchanged.

Verification
REQ-030 All weight codes 01, all x = 1, start, res_ready=1 -> res_data = 0x0E seven times; busy high for 22 cycles.
REQ-031 All weight codes 11, all x = 3 -> y = 0xD6 each without RELU, 0x00 each with TT_MULT_CTRL_RELU_EN.
REQ-032 Only input 0 to output 0 coded 01, x0 = 0x7F, others 0 -> y0 = 0x7F, y1..y6 = 0x00.
REQ-033 res_ready low 5 cycles on each byte -> res_data held stable, order y0..y6 preserved, no byte lost or duplicated.
REQ-034 start after 41 bytes is ignored (busy stays 0); 42nd byte then start -> normal run; extra byte offered while full -> in_ready = 0.
REQ-035 rst asserted at RUN step 3, then full reload and start -> outputs identical to an uninterrupted run; row = 0 the cycle after rst.

Source files
------------

// File: rtl/tt_um_mult_ctrl_if.sv
// tt_um_mult_ctrl_if: load stream, compute control, multiplier drive and result stream between host/multiplier (master) and sequencer (slave)
interface tt_um_mult_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        start;
  logic        busy;
  logic [2:0]  row;
  logic [15:0] VecIn;
  logic [27:0] W;
  logic [7:0]  VecOut;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  modport master (
    output in_valid, in_data, start, VecOut, res_ready,
    input  in_ready, busy, row, VecIn, W, res_valid, res_data
  );
  modport slave (
    input  in_valid, in_data, start, VecOut, res_ready,
    output in_ready, busy, row, VecIn, W, res_valid, res_data
  );
endinterface

// File: rtl/tt_um_mult_ctrl.sv
// tt_um_mult_ctrl: ternary mat-vec sequencer; ports clk, rst, bus (42-byte load stream, start/busy, row/VecIn/W drive, VecOut capture, res stream); define TT_MULT_CTRL_RELU_EN to zero negative results
module tt_um_mult_ctrl #(
  parameter int InLen    = 14,
  parameter int OutLen   = 7,
  parameter int BitWidth = 8
) (
  input logic            clk,
  input logic            rst,
  tt_um_mult_ctrl_if.slave bus
);
  localparam int NBytes = 4 * OutLen + InLen;
  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, OUT} state_t;
  state_t               state;
  logic [BitWidth-1:0]  mem [NBytes];
  logic [BitWidth-1:0]  y [OutLen];
  logic [27:0]          step_w [OutLen];
  logic [15:0]          pair [OutLen];
  logic [BitWidth-1:0]  cap;
  logic [5:0]           lcnt;
  logic [2:0]           cnt;
  logic [2:0]           nxt;
  assign nxt = cnt + 3'd1;
  assign bus.busy = state != IDLE;
  assign bus.in_ready = state == IDLE && lcnt < 6'(NBytes);
`ifdef TT_MULT_CTRL_RELU_EN
  assign cap = bus.VecOut[BitWidth-1] ? '0 : bus.VecOut;
`else
  assign cap = bus.VecOut;
`endif
  for (genvar i = 0; i < OutLen; i++) begin : g_step
    assign step_w[i] = {mem[4*i+3][3:0], mem[4*i+2], mem[4*i+1], mem[4*i]};
    assign pair[i] = {mem[4*OutLen+2*i+1], mem[4*OutLen+2*i]};
  end
  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) mem[lcnt] <= bus.in_data;
    if (state == DRAIN) y[cnt] <= cap;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lcnt          <= '0;
      cnt           <= '0;
      bus.row       <= '0;
      bus.W         <= '0;
      bus.VecIn     <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.start && lcnt == 6'(NBytes)) begin
            state     <= RUN;
            cnt       <= '0;
            bus.row   <= '0;
            bus.W     <= step_w[0];
            bus.VecIn <= pair[0];
          end else if (bus.in_valid && bus.in_ready) begin
            lcnt <= lcnt + 6'd1;
          end
        RUN:
          if (cnt == 3'(OutLen - 1)) begin
            state     <= FLUSH;
            bus.row   <= '0;
            bus.W     <= '0;
            bus.VecIn <= '0;
          end else begin
            cnt       <= nxt;
            bus.row   <= nxt;
            bus.W     <= step_w[nxt];
            bus.VecIn <= pair[nxt];
          end
        FLUSH: begin
          state   <= DRAIN;
          cnt     <= '0;
          bus.row <= 3'd1;
        end
        DRAIN:
          if (cnt == 3'(OutLen - 1)) begin
            state         <= OUT;
            cnt           <= '0;
            bus.res_valid <= 1'b1;
            bus.res_data  <= y[0];
          end else begin
            cnt     <= nxt;
            bus.row <= nxt == 3'(OutLen - 1) ? 3'd0 : nxt + 3'd1;
          end
        OUT:
          if (bus.res_ready) begin
            if (cnt == 3'(OutLen - 1)) begin
              state         <= IDLE;
              lcnt          <= '0;
              bus.res_valid <= 1'b0;
              bus.res_data  <= '0;
            end else begin
              cnt          <= nxt;
              bus.res_data <= y[nxt];
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tt_um_mult_ctrl.sv
// tb_tt_um_mult_ctrl: directed and random runs of the sequencer against a mock multiplier and an arithmetic mat-vec model
module tb_tt_um_mult_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  tt_um_mult_ctrl_if bif();
  tt_um_mult_ctrl dut (.clk(clk), .rst(rst), .bus(bif));
  int errs = 0;
  int checks = 0;
  logic [7:0] ld [42];
  logic [7:0] acc [7];
  logic [7:0] want [7];
  always @(posedge clk) begin : mock
    logic [7:0] t;
    logic [1:0] c;
    logic [7:0] xv;
    bif.VecOut <= bif.row < 3'd7 ? acc[bif.row] : 8'h00;
    for (int j = 0; j < 7; j++) begin
      t = bif.start ? 8'h00 : acc[j];
      for (int k = 0; k < 2; k++) begin
        c  = bif.W[2*(2*j+k) +: 2];
        xv = bif.VecIn[8*k +: 8];
        t  = c[1] ? t - xv : c[0] ? t + xv : t;
      end
      acc[j] <= t;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  function automatic void model();
    for (int j = 0; j < 7; j++) begin
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 14; i++) begin
        int p = 2 * (2 * j + i % 2);
        logic [7:0] b = ld[4 * (i / 2) + p / 8];
        logic [1:0] c = 2'(b >> (p % 8));
        s = c[1] ? s - ld[28+i] : c[0] ? s + ld[28+i] : s;
      end
`ifdef TT_MULT_CTRL_RELU_EN
      want[j] = s[7] ? 8'h00 : s;
`else
      want[j] = s;
`endif
    end
  endfunction
  function automatic void fill(input logic [7:0] w, input logic [7:0] x);
    for (int i = 0; i < 42; i++) ld[i] = i < 28 ? w : x;
  endfunction
  function automatic void fill_rand();
    for (int i = 0; i < 42; i++) ld[i] = 8'($urandom);
  endfunction
  task automatic load(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = ld[i];
      chk("in_ready", 32'(bif.in_ready), 1);
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
  endtask
  task automatic run(input string tag, input bit stall);
    int got = 0;
    int hold = 0;
    int bc = 0;
    bit rdy;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int c = 0; c < 400 && got < 7; c++) begin
      if (bif.busy) bc++;
      rdy = !stall || hold == 5;
      if (bif.res_valid) begin
        chk(tag, 32'(bif.res_data), 32'(want[got]));
        if (rdy) begin
          got++;
          hold = 0;
        end else hold++;
      end
      bif.res_ready = rdy;
      @(negedge clk);
    end
    bif.res_ready = 1'b1;
    chk("result_count", 32'(got), 7);
    chk("busy_cycles", 32'(bc), stall ? 57 : 22);
    chk("end_busy", 32'(bif.busy), 0);
    chk("end_res_valid", 32'(bif.res_valid), 0);
    chk("end_row", 32'(bif.row), 0);
    chk("end_W", 32'(bif.W), 0);
    chk("end_VecIn", 32'(bif.VecIn), 0);
    chk("end_in_ready", 32'(bif.in_ready), 1);
  endtask
  initial begin
    rst = 1'b1;
    bif.in_valid = 1'b0;
    bif.in_data = 8'h00;
    bif.start = 1'b0;
    bif.res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_in_ready", 32'(bif.in_ready), 1);
    chk("rst_res_valid", 32'(bif.res_valid), 0);
    chk("rst_res_data", 32'(bif.res_data), 0);
    chk("rst_row", 32'(bif.row), 0);
    chk("rst_W", 32'(bif.W), 0);
    chk("rst_VecIn", 32'(bif.VecIn), 0);
    rst = 1'b0;
    fill(8'h55, 8'h01);
    for (int s = 0; s < 7; s++) ld[4*s+3] = 8'hF5;
    for (int j = 0; j < 7; j++) want[j] = 8'h0E;
    load(0, 42);
    run("all_pass", 1'b0);
    fill(8'hFF, 8'h03);
`ifdef TT_MULT_CTRL_RELU_EN
    for (int j = 0; j < 7; j++) want[j] = 8'h00;
`else
    for (int j = 0; j < 7; j++) want[j] = 8'hD6;
`endif
    load(0, 42);
    run("all_negate", 1'b0);
    fill(8'h00, 8'h00);
    ld[0] = 8'h01;
    ld[28] = 8'h7F;
    for (int j = 0; j < 7; j++) want[j] = j == 0 ? 8'h7F : 8'h00;
    load(0, 42);
    run("single_weight", 1'b0);
    fill_rand();
    model();
    load(0, 42);
    run("stall", 1'b1);
    fill_rand();
    model();
    load(0, 41);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    chk("early_start_busy", 32'(bif.busy), 0);
    @(negedge clk);
    chk("early_start_busy2", 32'(bif.busy), 0);
    load(41, 42);
    bif.in_valid = 1'b1;
    bif.in_data = 8'hA5;
    chk("full_in_ready", 32'(bif.in_ready), 0);
    @(negedge clk);
    bif.in_valid = 1'b0;
    run("after_41", 1'b0);
    fill_rand();
    load(0, 42);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int c = 0; c < 20 && bif.row != 3'd3; c++) @(negedge clk);
    chk("run_step3", 32'(bif.row), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_row", 32'(bif.row), 0);
    chk("midrst_busy", 32'(bif.busy), 0);
    chk("midrst_W", 32'(bif.W), 0);
    chk("midrst_in_ready", 32'(bif.in_ready), 1);
    fill_rand();
    model();
    load(0, 42);
    run("after_rst", 1'b0);
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      model();
      load(0, 42);
      run("random", 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
